// File: rtl/phy_pkg.sv
// Shared PHY definitions: receiver FSM states and the default comma / idle
// symbols. The TX serializer imports the same constants so both ends agree.
package phy_pkg;

  // Receiver synchronisation states.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Default 8-bit alignment and idle symbols.
  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
  localparam logic [7:0] IDLE_DEFAULT  = 8'h7C;

endpackage

// File: rtl/serial_paralelo_sync_if.sv
// Bundle of the serial receiver's data-path signals.
//
// Handshake: there is no backpressure. valid_out is a one-cycle strobe that
// marks the cycle in which data_out and idle carry a newly aligned word; the
// consumer must take the word in that cycle. active is a level that is high
// only while the receiver is locked. state mirrors the receiver FSM.
interface serial_paralelo_sync_if #(
  parameter int WIDTH = 8
);
  import phy_pkg::*;

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             idle;
  logic             active;
  state_t           state;

  // Serial source side: drives the bit stream, observes the receiver.
  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  idle,
    input  active,
    input  state
  );

  // Receiver side.
  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output idle,
    output active,
    output state
  );

endinterface

// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel receiver with comma-based word alignment.
// Shifts an MSB-first stream into sr every clock, hunts for the comma at any
// bit offset, locks after SYNC_CNT aligned commas and then emits one word per
// WIDTH clocks. LOSS_CNT commas seen off the word boundary drop the lock.
module serial_paralelo_sync
  import phy_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] COMMA    = WIDTH'(COMMA_DEFAULT),
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(IDLE_DEFAULT),
  parameter int               SYNC_CNT = 4,
  parameter int               LOSS_CNT = 3
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  serial_paralelo_sync_if.slave bus
);

  // Elaboration-time legality of the parameters.
  if (WIDTH < 4) begin : g_width_chk
    $error("serial_paralelo_sync: WIDTH must be >= 4");
  end
  if (SYNC_CNT < 1) begin : g_sync_chk
    $error("serial_paralelo_sync: SYNC_CNT must be >= 1");
  end
  if (LOSS_CNT < 1) begin : g_loss_chk
    $error("serial_paralelo_sync: LOSS_CNT must be >= 1");
  end

  localparam int PW = $clog2(WIDTH);
  localparam int AW = $clog2(SYNC_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  localparam logic [PW-1:0] PH_LAST   = PW'(WIDTH - 1);
  localparam logic [AW-1:0] SYNC_LAST = AW'(SYNC_CNT);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT);

  logic [WIDTH-1:0] sr;
  logic [PW-1:0]    ph;
  logic [AW-1:0]    acnt;
  logic [LW-1:0]    mcnt;
  state_t           state_q;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_out_q;
  logic             idle_q;
  logic             active_q;

  logic             is_comma;
  logic             is_idle;
  logic             at_boundary;
  logic [AW-1:0]    acnt_inc;
  logic [LW-1:0]    mcnt_inc;

  // One comma comparator shared by every state.
  assign is_comma    = (sr == COMMA);
  assign is_idle     = (sr == IDLE_SYM);
  // ph is 0 in the cycle where sr holds a complete aligned word.
  assign at_boundary = (ph == '0);
  assign acnt_inc    = acnt + AW'(1);
  assign mcnt_inc    = mcnt + LW'(1);

  // Shift register, phase tracking, sync FSM and registered outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr          <= '0;
      ph          <= '0;
      acnt        <= '0;
      mcnt        <= '0;
      state_q     <= HUNT;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      idle_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      sr          <= {sr[WIDTH-2:0], bus.data_in};
      valid_out_q <= 1'b0;
      ph          <= (ph == PH_LAST) ? '0 : ph + PW'(1);

      unique case (state_q)
        HUNT: begin
          // Any offset may carry the comma; a hit defines the word phase,
          // so the next boundary falls exactly WIDTH cycles later.
          if (is_comma) begin
            ph   <= PW'(1);
            acnt <= AW'(1);
            if (SYNC_CNT == 1) begin
              state_q  <= LOCKED;
              active_q <= 1'b1;
            end else begin
              state_q <= ALIGN;
            end
          end
        end

        ALIGN: begin
          // Only boundary words count; anything but a comma restarts the hunt.
          if (at_boundary) begin
            if (is_comma) begin
              acnt <= acnt_inc;
              if (acnt_inc == SYNC_LAST) begin
                state_q  <= LOCKED;
                active_q <= 1'b1;
              end
            end else begin
              state_q <= HUNT;
              acnt    <= '0;
            end
          end
        end

        LOCKED: begin
          if (at_boundary) begin
            data_out_q  <= sr;
            valid_out_q <= 1'b1;
            idle_q      <= is_idle;
            if (is_comma) begin
              mcnt <= '0;
            end
          end else if (is_comma) begin
            // A comma off the boundary means the word phase has slipped.
            if (mcnt_inc == LOSS_LAST) begin
              state_q  <= HUNT;
              active_q <= 1'b0;
              idle_q   <= 1'b0;
              acnt     <= '0;
              mcnt     <= '0;
            end else begin
              mcnt <= mcnt_inc;
            end
          end
        end

        default: begin
          state_q <= HUNT;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.idle      = idle_q;
  assign bus.active    = active_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Directed bench for serial_paralelo_sync (WIDTH 8, comma BC, idle 7C,
// SYNC_CNT 4, LOSS_CNT 3). Words expected on the parallel side are queued as
// {idle, data} when their bits are driven and popped when valid_out strobes.
module tb_serial_paralelo_sync;
  import phy_pkg::*;

  localparam int W = 8;

  logic clk_32f;
  logic reset;
  int   checks;
  int   failures;
  logic prev_valid;

  logic [W:0] exp_q[$];

  serial_paralelo_sync_if #(.WIDTH(W)) bus ();

  serial_paralelo_sync #(
    .WIDTH    (W),
    .COMMA    (8'hBC),
    .IDLE_SYM (8'h7C),
    .SYNC_CNT (4),
    .LOSS_CNT (3)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  // Clock and reset.
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit; return 1 time unit after the edge that captured it.
  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Send the low n bits of w, MSB first.
  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_bits(w, W);
  endtask

  task automatic expect_word(input logic [W-1:0] w);
    exp_q.push_back({(w == 8'h7C), w});
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data"},   32'(bus.data_out),  32'h0);
    check({tag, "_valid"},  32'(bus.valid_out), 32'h0);
    check({tag, "_idle"},   32'(bus.idle),      32'h0);
    check({tag, "_active"}, 32'(bus.active),    32'h0);
  endtask

  // Scoreboard: every valid_out strobe must match the oldest queued word.
  always @(negedge clk_32f) begin
    if (reset) begin
      if (bus.valid_out) begin
        check("valid_back_to_back", 32'(prev_valid), 32'h0);
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(bus.valid_out), 32'h0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("sb_word", 32'({bus.idle, bus.data_out}), 32'(e));
        end
      end
      prev_valid = bus.valid_out;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    prev_valid  = 1'b0;
    reset       = 1'b0;
    bus.data_in = 1'b0;

    // Reset held with random serial data: everything stays at zero.
    for (int i = 0; i < 40; i++) begin
      bus.data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
      check_zero_outputs("reset_hold");
    end
    check("reset_state", 32'(bus.state), 32'(HUNT));
    reset = 1'b1;

    // Junk bits, four aligned commas, then a data word.
    send_bits(8'b010, 3);
    for (int i = 0; i < 4; i++) send_word(8'hBC);
    check("active_before_lock", 32'(bus.active), 32'h0);
    expect_word(8'hA5);
    send_bit(1'b1);
    check("active_at_lock", 32'(bus.active), 32'h1);
    check("state_locked", 32'(bus.state), 32'(LOCKED));
    send_bits(8'hA5, 7);
    check("a5_not_early", 32'(bus.valid_out), 32'h0);

    // Idle then ordinary word; each emitted one edge after its last bit.
    expect_word(8'h7C);
    send_bit(1'b0);
    check("a5_valid", 32'(bus.valid_out), 32'h1);
    check("a5_data", 32'(bus.data_out), 32'hA5);
    send_bits(8'h7C, 7);
    expect_word(8'h12);
    send_bit(1'b0);
    check("idle_valid", 32'(bus.valid_out), 32'h1);
    check("idle_data", 32'(bus.data_out), 32'h7C);
    check("idle_flag_set", 32'(bus.idle), 32'h1);
    send_bits(8'h12, 7);

    // One extra bit slips the phase; boundary words become {x, BC[7:1]}.
    expect_word(8'h5E);
    expect_word(8'h5E);
    expect_word(8'h5E);
    send_bit(1'b0);
    check("w12_data", 32'(bus.data_out), 32'h12);
    check("idle_flag_clear", 32'(bus.idle), 32'h0);
    send_word(8'hBC);
    send_word(8'hBC);
    check("still_locked_2_slips", 32'(bus.active), 32'h1);
    send_word(8'hBC);
    check("still_locked_before_3rd_eval", 32'(bus.active), 32'h1);
    send_bit(1'b1);
    check("lock_lost", 32'(bus.active), 32'h0);
    check("state_hunt_after_loss", 32'(bus.state), 32'(HUNT));
    send_bits(8'hBC, 7);
    for (int i = 0; i < 3; i++) send_word(8'hBC);
    check("no_relock_yet", 32'(bus.active), 32'h0);
    expect_word(8'h81);
    send_bit(1'b1);
    check("relock", 32'(bus.active), 32'h1);
    send_bits(8'h81, 7);

    // Reset four bits into the next symbol while locked.
    send_bit(1'b1);
    check("w81_data", 32'(bus.data_out), 32'h81);
    send_bits(8'b111, 3);
    check("locked_before_reset", 32'(bus.active), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      check_zero_outputs("reset_mid");
    end
    reset = 1'b1;

    // Three commas then a bad word: alignment abandoned, full re-hunt.
    for (int i = 0; i < 3; i++) send_word(8'hBC);
    send_word(8'h55);
    check("no_lock_after_55", 32'(bus.active), 32'h0);
    for (int i = 0; i < 4; i++) send_word(8'hBC);
    check("no_lock_before_4th_eval", 32'(bus.active), 32'h0);
    expect_word(8'h3C);
    send_bit(1'b0);
    check("lock_second_run", 32'(bus.active), 32'h1);
    send_bits(8'h3C, 7);
    send_bit(1'b0);
    check("w3c_valid", 32'(bus.valid_out), 32'h1);
    check("w3c_data", 32'(bus.data_out), 32'h3C);
    @(negedge clk_32f);
    #1;
    reset = 1'b0;
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_sync.md
# serial_paralelo_sync

Parametrised serial-to-parallel receiver with comma-based word alignment, sync acquisition and loss-of-sync detection for the PHY layer. Accepts an MSB-first serial stream on the bit clock and searches every bit offset for the comma symbol. It locks after a programmable number of aligned commas, then emits aligned words with a one-cycle valid strobe and flags the idle symbol. It replaces the fixed 8-bit, fixed-offset, two-clock deserializer.

## Interface
- WIDTH, 8: symbol width in bits; legal range ≥4.
- COMMA, 8'hBC: alignment symbol, WIDTH bits.
- IDLE_SYM, 8'h7C: idle symbol, WIDTH bits.
- SYNC_CNT, 4: consecutive aligned commas required to lock; legal range ≥1.
- LOSS_CNT, 3: misaligned commas that drop lock; legal range ≥1.
- clk_32f  input  1  bit clock; single clock of the block, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial data, MSB of each symbol first, one bit per clk_32f.
- data_out  output  WIDTH  last aligned word; reset value 0.
- valid_out  output  1  one-cycle strobe, data_out is new; reset value 0.
- idle  output  1  level, last emitted word == IDLE_SYM; reset value 0.
- active  output  1  level, block is in LOCKED; reset value 0.

## Operation
- Shift register sr[WIDTH-1:0] shifts left every cycle, data_in enters at LSB. After WIDTH shifts, the first bit received sits at the MSB.
- Phase counter ph, 0..WIDTH-1, wraps. The boundary cycle is the cycle in which sr holds a complete aligned word. Boundaries occur every WIDTH cycles.
- Alignment counter acnt, 0..SYNC_CNT. Misalignment counter mcnt, 0..LOSS_CNT.
- State HUNT: checks sr == COMMA every cycle.
  - On a match, that cycle becomes a boundary and ph restarts so the next boundary is WIDTH cycles later. acnt = 1.
  - Next state is ALIGN, or LOCKED directly if SYNC_CNT == 1.
- State ALIGN: evaluated at boundaries only.
  - sr == COMMA: acnt+1. When acnt reaches SYNC_CNT, go to LOCKED.
  - Any other word: go to HUNT, acnt = 0.
  - No valid_out is issued in ALIGN, including for the locking comma.
- State LOCKED: active = 1.
  - At every boundary: data_out <= sr, valid_out pulses, idle <= (sr == IDLE_SYM). Commas are emitted like any other word.
  - At a boundary with sr == COMMA: mcnt = 0.
  - At a non-boundary cycle with sr == COMMA: mcnt+1. When mcnt reaches LOSS_CNT, go to HUNT.
  - On entering HUNT from LOCKED: active, idle, acnt and mcnt are cleared in the same edge; data_out holds its last value.
- Reset (any time, including mid-word or while locked): all counters, sr and outputs go to 0 asynchronously, state goes to HUNT. Full reacquisition is required after release.

## Timing
- Latency: the last bit of a word is captured at edge k. data_out, valid_out and idle update at edge k+1 (one clock).
- valid_out is high for exactly one cycle per WIDTH cycles while LOCKED, and never two cycles in a row.
- active rises at the edge that evaluates the SYNC_CNT-th aligned comma. The first valid_out follows WIDTH cycles after that.
- active falls at the edge where mcnt reaches LOSS_CNT. No valid_out is issued on that edge or after it.
- The reset release edge is not a shift edge. The first shift occurs on the first rising edge with reset high.

## Structure
- Shared package phy_pkg holds:
  - the state enum {HUNT, ALIGN, LOCKED};
  - the default COMMA / IDLE_SYM constants (8'hBC, 8'h7C), reused by the TX serializer.
- Single module, no sub-module. The comma compare is one equality reused by all states.
- Parameter legality (the legal ranges listed under Interface) is checked at elaboration.

## Test plan
- Reset held low with random data_in for 40 cycles -> data_out=0, valid_out=0, idle=0, active=0 throughout.
- 3 junk bits, then BC×4, then A5 -> active rises on the 4th BC boundary. valid_out pulses once with data_out=8'hA5, 9 cycles after the last BC bit.
- BC×3, then 55, then BC×4, then 3C -> no lock after the 55. Lock follows the second BC run; the first emitted word is 8'h3C.
- Locked, send 7C then 12 -> valid_out with data_out=7C and idle=1, then data_out=12 and idle=0.
- Locked, then insert one extra bit so every later BC is 1-bit misaligned; send BC×3 -> active drops on the 3rd misaligned comma. Relocks after 4 commas at the new offset.
- Locked, assert reset mid-word (4 bits into a symbol) -> all outputs 0 immediately, without a clock edge. After release, BC×4 is needed before any valid_out.
